// File: rtl/mux_nch_reg.sv
// N-channel, W-bit registered multiplexer with valid/ready on every input and on the
// output. Channel selection is either an external index (manual) or round-robin
// arbitration over the requesting channels.
module mux_nch_reg #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 8,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_chan,
    output logic            out_valid,
    input  logic            out_ready
);

    // One extra bit so that N itself and pointer+offset sums are representable.
    localparam int unsigned SWP = SW + 1;
    localparam logic [SW:0] NumChan = SWP'(N);
    localparam logic [SW-1:0] LastChan = SW'(N - 1);

    logic [W-1:0]  chan_data [N];

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_chan_q, out_chan_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          rr_found;
    logic [SW-1:0] rr_idx;
    logic [SW:0]   rr_sum;
    logic          man_found;
    logic          cand_ok;
    logic [SW-1:0] cand_idx;
    logic          load;
    logic          grant;

    // Unpack the flat input bus into per-channel words.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            chan_data[i] = in_data[i*W +: W];
        end
    end

    // Round-robin search: first valid channel starting just after ptr, wrapping to ptr.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            rr_sum = {1'b0, ptr_q} + SWP'(k);
            // ptr < N and k <= N, so a single subtraction completes the modulo.
            if (rr_sum >= NumChan) begin
                rr_sum = rr_sum - NumChan;
            end
            if (!rr_found && in_valid[rr_sum[SW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_sum[SW-1:0];
            end
        end
    end

    // Manual candidate exists only for an in-range select with a valid channel.
    always_comb begin
        man_found = 1'b0;
        if ({1'b0, sel} < NumChan) begin
            man_found = in_valid[sel];
        end
    end

    // Grant decision and the one-hot input accept.
    always_comb begin
        cand_ok  = mode ? rr_found : man_found;
        cand_idx = mode ? rr_idx : sel;
        load     = !out_valid_q || out_ready;
        // No handshake may complete on a reset cycle.
        grant    = rst_n && load && cand_ok;
        in_ready = '0;
        if (grant) begin
            in_ready[cand_idx] = 1'b1;
        end
    end

    // Next state for the output register and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (grant) begin
            out_data_d  = chan_data[cand_idx];
            out_chan_d  = cand_idx;
            out_valid_d = 1'b1;
            // Manual grants must not disturb the arbitration order.
            if (mode) begin
                ptr_d = cand_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset; ptr=N-1 gives channel 0 priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= LastChan;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

    // At most one channel accepted per cycle.
    a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));

    // Only a requesting channel is ever accepted.
    a_ready_needs_valid: assert property (@(posedge clk) (in_ready & ~in_valid) == '0);

    // Held output is frozen while the consumer stalls.
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_chan));

endmodule

// File: tb/tb_mux_nch_reg.sv
// Randomized and directed bench for mux_nch_reg. Two instances (N=4 and N=3) are
// checked every cycle against a behavioural model of the selection rules.
module tb_mux_nch_reg;

    localparam int AN = 4;
    localparam int BN = 3;
    localparam int W  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;

    logic [AN*W-1:0] a_in_data;
    logic [AN-1:0]   a_in_valid;
    logic [AN-1:0]   a_in_ready;
    logic            a_mode;
    logic [1:0]      a_sel;
    logic [W-1:0]    a_out_data;
    logic [1:0]      a_out_chan;
    logic            a_out_valid;
    logic            a_out_ready;

    logic [BN*W-1:0] b_in_data;
    logic [BN-1:0]   b_in_valid;
    logic [BN-1:0]   b_in_ready;
    logic            b_mode;
    logic [1:0]      b_sel;
    logic [W-1:0]    b_out_data;
    logic [1:0]      b_out_chan;
    logic            b_out_valid;
    logic            b_out_ready;

    mux_nch_reg #(.N(AN), .W(W)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .mode      (a_mode),
        .sel       (a_sel),
        .out_data  (a_out_data),
        .out_chan  (a_out_chan),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready)
    );

    mux_nch_reg #(.N(BN), .W(W)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .mode      (b_mode),
        .sel       (b_sel),
        .out_data  (b_out_data),
        .out_chan  (b_out_chan),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    int checks = 0;
    int errors = 0;

    // Model state per instance.
    bit         ma_valid = 1'b0;
    logic [7:0] ma_data  = '0;
    int         ma_chan  = 0;
    int         ma_ptr   = AN - 1;
    bit         mb_valid = 1'b0;
    logic [7:0] mb_data  = '0;
    int         mb_chan  = 0;
    int         mb_ptr   = BN - 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel granted this cycle by the rules, or -1 for none.
    function automatic int pick(input int n, input int ptr, input bit md, input int s,
                                input logic [3:0] v, input bit ov, input bit ordy,
                                input bit rst_ok);
        if (!rst_ok) return -1;
        if (ov && !ordy) return -1;
        if (!md) begin
            if (s < n && v[s]) return s;
            return -1;
        end
        for (int k = 1; k <= n; k++) begin
            int c;
            c = (ptr + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int g);
        if (g < 0) return 32'd0;
        return 32'd1 << g;
    endfunction

    // One clock: check accepts before the edge, advance the model, check outputs after.
    task automatic tick();
        int         ga, gb;
        logic [7:0] da, db;
        bit         am, bm, rs;
        #1;
        am = a_mode;
        bm = b_mode;
        rs = rst_n;
        ga = pick(AN, ma_ptr, am, int'(a_sel), a_in_valid, ma_valid, a_out_ready, rs);
        gb = pick(BN, mb_ptr, bm, int'(b_sel), {1'b0, b_in_valid}, mb_valid, b_out_ready, rs);
        check_eq("a_in_ready", 32'(a_in_ready), onehot(ga));
        check_eq("b_in_ready", 32'(b_in_ready), onehot(gb));
        da = (ga >= 0) ? a_in_data[ga*W +: W] : 8'h00;
        db = (gb >= 0) ? b_in_data[gb*W +: W] : 8'h00;
        @(posedge clk);
        #1;
        if (!rs) begin
            ma_valid = 1'b0; ma_data = '0; ma_chan = 0; ma_ptr = AN - 1;
            mb_valid = 1'b0; mb_data = '0; mb_chan = 0; mb_ptr = BN - 1;
        end else begin
            if (ga >= 0) begin
                ma_valid = 1'b1; ma_data = da; ma_chan = ga;
                if (am) ma_ptr = ga;
            end else if (ma_valid && a_out_ready) begin
                ma_valid = 1'b0;
            end
            if (gb >= 0) begin
                mb_valid = 1'b1; mb_data = db; mb_chan = gb;
                if (bm) mb_ptr = gb;
            end else if (mb_valid && b_out_ready) begin
                mb_valid = 1'b0;
            end
        end
        check_eq("a_out_valid", 32'(a_out_valid), 32'(ma_valid));
        check_eq("a_out_data", 32'(a_out_data), 32'(ma_data));
        check_eq("a_out_chan", 32'(a_out_chan), 32'(ma_chan));
        check_eq("b_out_valid", 32'(b_out_valid), 32'(mb_valid));
        check_eq("b_out_data", 32'(b_out_data), 32'(mb_data));
        check_eq("b_out_chan", 32'(b_out_chan), 32'(mb_chan));
    endtask

    initial begin
        rst_n       = 1'b0;
        a_in_data   = 32'($urandom);
        a_in_valid  = 4'hF;
        a_mode      = 1'b1;
        a_sel       = 2'd0;
        a_out_ready = 1'b1;
        b_in_data   = 24'($urandom);
        b_in_valid  = 3'h7;
        b_mode      = 1'b1;
        b_sel       = 2'd0;
        b_out_ready = 1'b1;

        // Reset with every channel requesting.
        repeat (2) tick();
        check_eq("rst_a_valid", 32'(a_out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("first_rr_a", 32'(a_out_chan), 32'd0);
        check_eq("first_rr_b", 32'(b_out_chan), 32'd0);

        // Manual pass-through on A; out-of-range select drains B.
        a_mode    = 1'b0;
        a_sel     = 2'd2;
        a_in_data = 32'h11A5_3344;
        b_mode    = 1'b0;
        b_sel     = 2'd3;
        tick();
        check_eq("manual_data", 32'(a_out_data), 32'hA5);
        check_eq("sel_oob_drain", 32'(b_out_valid), 32'd0);
        tick();

        // Backpressure: hold 0x3C while inputs churn.
        a_sel     = 2'd1;
        a_in_data = 32'h0000_3C00;
        tick();
        a_out_ready = 1'b0;
        repeat (5) begin
            a_in_data  = 32'($urandom);
            a_in_valid = 4'($urandom);
            a_sel      = 2'($urandom);
            a_mode     = 1'($urandom);
            tick();
            check_eq("stall_data", 32'(a_out_data), 32'h3C);
        end
        a_out_ready = 1'b1;
        a_mode      = 1'b0;
        a_sel       = 2'd0;
        a_in_valid  = 4'hF;
        a_in_data   = 32'h0000_0077;
        tick();
        check_eq("no_bubble", 32'(a_out_data), 32'h77);

        // Mode switch on B: round-robin grant to 1, then next goes to 2.
        b_mode     = 1'b1;
        b_in_valid = 3'b010;
        tick();
        b_in_valid = 3'b111;
        tick();
        check_eq("b_after_1", 32'(b_out_chan), 32'd2);

        // Round-robin rotation then skip on A.
        a_mode     = 1'b1;
        a_in_valid = 4'hF;
        repeat (5) tick();
        a_in_valid = 4'b1010;
        repeat (4) tick();

        // Reset while full and stalled.
        a_out_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_eq("midrst_valid", 32'(a_out_valid), 32'd0);
        rst_n       = 1'b1;
        a_in_valid  = 4'hF;
        a_out_ready = 1'b1;
        tick();
        check_eq("midrst_chan0", 32'(a_out_chan), 32'd0);

        // Randomized traffic with occasional resets.
        repeat (500) begin
            rst_n       = ($urandom_range(0, 49) != 0);
            a_in_data   = 32'($urandom);
            a_in_valid  = 4'($urandom);
            a_mode      = ($urandom_range(0, 3) != 0);
            a_sel       = 2'($urandom);
            a_out_ready = ($urandom_range(0, 3) != 0);
            b_in_data   = 24'($urandom);
            b_in_valid  = 3'($urandom);
            b_mode      = 1'($urandom);
            b_sel       = 2'($urandom);
            b_out_ready = 1'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_nch_reg.md
# mux_nch_reg

Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output, and two selection modes: externally selected channel or round-robin arbitration across requesting channels. It is the generalised successor of the gate-level 4:1 mux in the datapath library. It sits between several producer streams and a single consumer, replacing fixed combinational selection wherever flow control or fair sharing is needed.

## Interface
- `N`, default 4: number of input channels, N >= 2.
- `W`, default 8: data width per channel.
- `SW`, default `$clog2(N)`: select/channel-index width. Derived; do not override.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_data` input N*W: channel i occupies bits [i*W +: W].
- `in_valid` input N: per-channel data valid.
- `in_ready` output N: per-channel accept; at most one bit is high in any cycle.
- `mode` input 1: 0 = manual select, 1 = round-robin.
- `sel` input SW: channel index used in manual mode.
- `out_data` output W: registered selected data.
- `out_chan` output SW: index of the channel that produced `out_data`.
- `out_valid` output 1: output register holds data.
- `out_ready` input 1: consumer accepts.

## Operation
- Single output register with two states. EMPTY: `out_valid`=0. FULL: `out_valid`=1.
- `load = !out_valid || out_ready`. The register can take new data this cycle.
- Candidate channel `c`:
  - Manual mode: `c = sel`. If `sel >= N`, there is no candidate.
  - Round-robin mode: the first i with `in_valid[i]`=1, searching `ptr+1, ptr+2, …` modulo N, ending at `ptr` itself.
- Grant: `g = load && candidate exists && in_valid[c]`.
  - `in_ready[c] = g`. All other `in_ready` bits are 0.
  - `in_ready` is combinational from `in_valid`, `mode`, `sel`, `out_valid` and `out_ready`. Producers must not make `in_valid` depend on `in_ready`.
- On a clock edge with `g`=1: `out_data <= in_data[c]`, `out_chan <= c`, `out_valid <= 1`.
- On a clock edge with `g`=0 and `out_valid && out_ready`: `out_valid <= 0`. `out_data` and `out_chan` hold their last values.
- On a clock edge with `g`=0 and `out_valid && !out_ready`: all outputs hold. Output data must be stable under backpressure.
- Round-robin pointer `ptr` (SW bits):
  - Updates to `c` only on a grant made in round-robin mode.
  - Manual-mode grants leave `ptr` unchanged.
- `mode` and `sel` are sampled combinationally each cycle. A change affects the grant in the same cycle. Data already in the register is never altered.

## Timing
- Reset values (clock edge with `rst_n`=0): `out_valid`=0, `out_data`=0, `out_chan`=0, `ptr`=N-1 (channel 0 has first priority after reset).
- While `rst_n`=0, all `in_ready` bits are 0.
- Reset mid-transfer discards the held word. No handshake completes on a reset cycle.
- Latency: input handshake in cycle t gives `out_valid`=1 with that data from cycle t+1.
- Throughput: one word per cycle while `out_ready`=1 and a candidate is valid. An output handshake and an input grant in the same cycle replace the word with no bubble.
- Round-robin fairness: with all N channels continuously valid and `out_ready`=1, grants rotate 0,1,…,N-1,0 with no channel granted twice in N consecutive grants.
- No candidate, or candidate not valid: no grant; the register drains normally.
- Pointer wrap: from `ptr`=N-1, the search starts at 0.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with all `in_valid`=1. Required: `out_valid`=0, `out_data`=0, `out_chan`=0, `in_ready`=0. Then release with `mode`=1. Required: first grant to channel 0.
- Manual pass-through: N=4, W=8, `mode`=0, `sel`=2, `in_data[2]`=0xA5, all valid, `out_ready`=1. Required: `in_ready`=4'b0100, then next cycle `out_data`=0xA5 and `out_chan`=2.
- Backpressure: register full with 0x3C and `out_ready`=0 for 5 cycles while inputs change. Required: `out_data` stays 0x3C, `out_valid`=1, `in_ready`=0. Raise `out_ready`. Required: a new word loads the same cycle, no bubble.
- Round-robin rotation and skip: `mode`=1, `out_ready`=1.
  - All valid. Required: `out_chan` sequence 0,1,2,3,0.
  - Then only channels 1 and 3 valid. Required: 1,3,1,3.
- Out-of-range select and mode switch (N=3, SW=2): `mode`=0, `sel`=3, all valid. Required: no `in_ready` and the register drains. Then switch to `mode`=1 after a round-robin grant to channel 1. Required: next grant to channel 2.
- Reset mid-operation: assert `rst_n`=0 while the register is full and `out_ready`=0. Required: `out_valid`=0 next cycle and `ptr` back to N-1, so the next round-robin grant goes to channel 0.
